// File: rtl/bin_to_7seg_scan_if.sv
// Value/control and display signal bundle for bin_to_7seg_scan.
// The master side supplies value and control; the slave side drives the display.
interface bin_to_7seg_scan_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] val;
    logic             load;
    logic             blank_lz;
    logic             busy;
    logic             ovf;
    logic [6:0]       seg;
    logic [7:0]       anodes;

    modport master (
        output val, load, blank_lz,
        input  busy, ovf, seg, anodes
    );

    modport slave (
        input  val, load, blank_lz,
        output busy, ovf, seg, anodes
    );
endinterface

// File: rtl/bin_to_7seg_scan.sv
// Binary to BCD conversion (sequential double-dabble) feeding a multiplexed
// 8-anode 7-segment scanner with leading-zero blanking and overflow dashes.
module bin_to_7seg_scan #(
    parameter int WIDTH       = 8,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                clk,
    input  logic                reset,
    bin_to_7seg_scan_if.slave   bus
);
    // Decimal digits needed for the largest WIDTH-bit value.
    function automatic int f_dec_digits(input int w);
        longint unsigned v;
        int              n;
        v = (64'd1 << w) - 64'd1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (v != 0) begin
                v = v / 10;
                n++;
            end
        end
        return n;
    endfunction

    function automatic logic [6:0] f_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction

    localparam int NIB_MIN = f_dec_digits(WIDTH);
    localparam int NIB     = (NIB_MIN > DIGITS) ? NIB_MIN : DIGITS;
    localparam int CNT_W   = $clog2(WIDTH + 1);
    localparam int REF_W   = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t              r_state, w_state_next;
    logic [WIDTH-1:0]    r_bin, w_bin_next;
    logic [4*NIB-1:0]    r_bcd, w_bcd_next, w_bcd_adj;
    logic [CNT_W-1:0]    r_cnt, w_cnt_next;
    logic                w_latch;
    logic                w_upper_nz;
    logic [4*DIGITS-1:0] r_disp;
    logic                r_ovf;

    logic [REF_W-1:0]    r_ref;
    logic [2:0]          r_scan;
    logic [3:0]          w_nibs [8];
    logic [7:0]          w_hi_zero;
    logic [6:0]          r_seg;
    logic [7:0]          r_anodes;

    genvar gi;
    generate
        for (gi = 0; gi < NIB; gi++) begin : g_adj
            assign w_bcd_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ?
                                          r_bcd[4*gi +: 4] + 4'd3 : r_bcd[4*gi +: 4];
        end

        if (NIB > DIGITS) begin : g_ovf
            assign w_upper_nz = |r_bcd[4*NIB-1:4*DIGITS];
        end else begin : g_no_ovf
            assign w_upper_nz = 1'b0;
        end

        // Per slot: the digit value and whether it and everything above it is zero.
        for (gi = 0; gi < 8; gi++) begin : g_slot
            if (gi < DIGITS) begin : g_on
                assign w_nibs[gi]    = r_disp[4*gi +: 4];
                assign w_hi_zero[gi] = (r_disp[4*DIGITS-1:4*gi] == '0);
            end else begin : g_off
                assign w_nibs[gi]    = 4'd0;
                assign w_hi_zero[gi] = 1'b1;
            end
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_bin_next   = r_bin;
        w_bcd_next   = r_bcd;
        w_cnt_next   = r_cnt;
        w_latch      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.load) begin
                    w_bin_next   = bus.val;
                    w_bcd_next   = '0;
                    w_cnt_next   = CNT_W'(WIDTH);
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                {w_bcd_next, w_bin_next} = {w_bcd_adj, r_bin} << 1;
                w_cnt_next = r_cnt - 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_latch      = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_bin   <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_disp  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_bin   <= w_bin_next;
            r_bcd   <= w_bcd_next;
            r_cnt   <= w_cnt_next;
            if (w_latch) begin
                r_disp <= r_bcd[4*DIGITS-1:0];
                r_ovf  <= w_upper_nz;
            end
        end
    end

    // Scan timing is free-running and independent of any conversion.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ref  <= '0;
            r_scan <= '0;
        end else if (r_ref == REF_W'(REFRESH_DIV - 1)) begin
            r_ref  <= '0;
            r_scan <= (r_scan == 3'(DIGITS - 1)) ? 3'd0 : r_scan + 3'd1;
        end else begin
            r_ref <= r_ref + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_seg    <= 7'h7F;
            r_anodes <= 8'hFF;
        end else if (r_ovf) begin
            r_seg    <= 7'b0111111;
            r_anodes <= ~(8'd1 << r_scan);
        end else if (bus.blank_lz && (r_scan != 3'd0) && w_hi_zero[r_scan]) begin
            r_seg    <= 7'h7F;
            r_anodes <= 8'hFF;
        end else begin
            r_seg    <= f_decode(w_nibs[r_scan]);
            r_anodes <= ~(8'd1 << r_scan);
        end
    end

    assign bus.busy   = (r_state != S_IDLE);
    assign bus.ovf    = r_ovf;
    assign bus.seg    = r_seg;
    assign bus.anodes = r_anodes;
endmodule

// File: doc/bin_to_7seg_scan.md
# bin_to_7seg_scan

Parametrised binary-to-decimal display driver for the board's 8-digit multiplexed 7-segment display. It takes an unsigned binary value of any width up to 32 bits and converts it to BCD with a sequential shift-add-3 (double-dabble) engine. It then time-multiplexes the decimal digits onto the shared segment bus, with optional leading-zero blanking and overflow indication. It generalises the single-digit value/tens-flag decoder path to N digits with a real scan clock.

## Interface
- WIDTH, 8: binary input width, 1..32.
- DIGITS, 4: number of displayed digits, 1..8; anode positions ≥ DIGITS are permanently off.
- REFRESH_DIV, 100000: clk cycles each digit is driven before the scan advances; ≥ 2.

- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- val  in  WIDTH  unsigned binary value to display.
- load  in  1  single-cycle request to sample val and start a conversion.
- blank_lz  in  1  1 = blank leading zeros; 0 = show all DIGITS digits.
- busy  out  1  conversion in progress; load is ignored while high.
- ovf  out  1  last converted value needs more than DIGITS decimal digits.
- seg  out  7  segments {g,f,e,d,c,b,a}, active low.
- anodes  out  8  digit enables, active low; bit i = digit i (digit 0 = least significant).

## Operation
- Conversion FSM has three states: IDLE, SHIFT, DONE.
- IDLE: if load=1, capture val into the shift register, clear the BCD register, set the shift count to WIDTH, and go to SHIFT. If load=0, stay.
- SHIFT: each cycle, add 3 to every BCD nibble ≥ 5, then shift {bcd, bin} left one bit and decrement the count. After the WIDTH-th shift, go to DONE.
- DONE: latch the BCD result into the display register, set ovf if any nibble above DIGITS-1 is nonzero, then go to IDLE.
- The BCD register is sized internally to ceil(WIDTH·log10 2) nibbles, minimum DIGITS, so ovf detection is exact.
- busy = 1 in SHIFT and DONE; load in those states is ignored, not queued.
- Display register and ovf hold their values until the next DONE.
- Scan: the refresh counter runs 0..REFRESH_DIV-1. At the terminal count, the scan index advances mod DIGITS (wraps from DIGITS-1 to 0). Scanning runs regardless of busy.
- Per scan slot i:
  - If ovf=1, show dash (seg = 7'b0111111) on every digit.
  - Otherwise, if blank_lz=1 and i > 0 and every nibble at index ≥ i is zero, the digit is blanked (anode i high, seg 7'h7F).
  - Otherwise, drive the decoded digit.
  - Digit 0 is never blanked.
- Decoding, active low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Exactly one anode is low at a time, or none when the slot is blanked.

## Timing
- Reset values: busy=0, ovf=0, display register=0, scan index=0, refresh counter=0, FSM=IDLE, seg=7'h7F, anodes=8'hFF.
- seg and anodes are registered and reflect the scan index and display register one cycle late. The first cycle after reset deasserts, anodes=8'hFE and seg=1000000 (digit 0 shows "0").
- load sampled at edge E0 (in IDLE):
  - busy is high from E0 through edge E0+WIDTH+1, i.e. WIDTH+1 cycles.
  - Display register and ovf update at E0+WIDTH+1.
  - seg/anodes reflect the new value from E0+WIDTH+2.
- A load on the same edge busy falls is accepted (FSM is back in IDLE).
- Reset asserted mid-conversion: the conversion is discarded and all reset values are restored on that edge.
- A val change after the load edge has no effect on the conversion in flight.

## Test plan
All scenarios use WIDTH=8, DIGITS=4, REFRESH_DIV=4 unless stated.

- Reset, no load: anodes cycle FE→(blanked)→… with blank_lz=1. Only digit 0 lights, seg=1000000. busy=0, ovf=0.
- val=255, load pulse, blank_lz=1: busy high exactly 9 cycles. Digits 0/1/2 show 5/5/2 (0010010, 0010010, 0100100); anode 3 never low.
- val=7, blank_lz toggled 1→0: with 1, only anode 0 ever low. With 0, digits 3..1 show 1000000 and digit 0 shows 1111000.
- DIGITS=2, val=100: ovf=1 and both digits show 0111111. Then load val=99: ovf=0, digits show 9/9.
- load val=12 then load val=34 two cycles later (busy): the second load is ignored and the display shows 12. A load at busy's falling edge is accepted.
- reset asserted 3 cycles into converting val=200: busy=0 and display 0 next cycle. No later update to 200 appears.
